// File: rtl/sdram_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// sdram_cmd_sequencer
//   SDRAM command sequencer for single-beat reads and writes. It runs the
//   power-up init (PRE-ALL, 2x REF, MRS) and periodic auto-refresh, and serves
//   each access as ACTIVATE then READ/WRITE with auto-precharge. It also drives
//   the direction/strobe controls used by the DQ data-path block.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   req_valid_i/ready_o    request handshake (accept when both high)
//   req_write_i            1 = write, 0 = read
//   req_addr_i             {bank, row, col}
//   done_o                 one-cycle completion pulse
//   init_done_o            high once the init sequence has finished
//   cmd_write_active_o     data path drives DQ (same edge as WR)
//   cmd_read_active_o      data path captures DQ (CAS_LAT after RD)
//   sdram_rdata_valid_o    read data valid (CAS_LAT after RD)
//   SDRAM_*                registered SDRAM command/address pins
// ---------------------------------------------------------------------------
module sdram_cmd_sequencer #(
   parameter int BANK_W       = 2,
   parameter int ROW_W        = 13,
   parameter int COL_W        = 9,
   parameter int CAS_LAT      = 2,
   parameter int T_RCD        = 2,
   parameter int T_RP         = 2,
   parameter int T_WR         = 2,
   parameter int T_RFC        = 7,
   parameter int REF_INTERVAL = 780,
   parameter int INIT_WAIT    = 10000,
   parameter logic [ROW_W-1:0] MODE_REG = 'h020
) (
   input  logic                            HCLK,
   input  logic                            HRESETn,
   input  logic                            req_valid_i,
   input  logic                            req_write_i,
   input  logic [BANK_W+ROW_W+COL_W-1:0]   req_addr_i,
   output logic                            req_ready_o,
   output logic                            done_o,
   output logic                            init_done_o,
   output logic                            cmd_write_active_o,
   output logic                            cmd_read_active_o,
   output logic                            sdram_rdata_valid_o,
   output logic                            SDRAM_CKE,
   output logic                            SDRAM_CS_N,
   output logic                            SDRAM_RAS_N,
   output logic                            SDRAM_CAS_N,
   output logic                            SDRAM_WE_N,
   output logic [BANK_W-1:0]               SDRAM_BA,
   output logic [ROW_W-1:0]                SDRAM_A
);

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Wait loads. A state loaded with N emits its action on the edge after the
   // counter reaches zero, so "N NOPs then a command" loads N, while "wait N
   // cycles then be IDLE" loads N-1. Zero-length waits collapse to one cycle.
   localparam int INIT_CNT  = (INIT_WAIT > 0) ? INIT_WAIT : 1;
   localparam int RP_NOP    = (T_RP  > 0) ? T_RP  : 1;
   localparam int RFC_NOP   = (T_RFC > 0) ? T_RFC : 1;
   localparam int RCD_NOP   = (T_RCD > 1) ? T_RCD - 1 : 0;
   localparam int CAS_WAIT  = (CAS_LAT > 1) ? CAS_LAT - 1 : 0;
   localparam int RP_IDLE   = (T_RP > 1) ? T_RP - 1 : 0;
   localparam int WR_IDLE   = (T_WR + T_RP > 1) ? T_WR + T_RP - 1 : 0;
   localparam int RFC_IDLE  = (T_RFC > 1) ? T_RFC - 1 : 0;
   localparam int MRS_IDLE  = 1;
   localparam int CNT_MAX   = imax(imax(imax(INIT_CNT, RP_NOP), imax(RFC_NOP, RCD_NOP)),
                                   imax(imax(CAS_WAIT, WR_IDLE), imax(RFC_IDLE, MRS_IDLE)));
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int REF_W     = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;
   localparam logic [3:0] CMD_DES = 4'b1111;
   localparam logic [ROW_W-1:0] A10 = ROW_W'(1) << 10;

   typedef enum logic [3:0] {
      S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
      S_IDLE, S_REF, S_ACT, S_CAS, S_RECOVER
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_dec;
   logic                w_cnt_zero;
   logic                r_cke;
   logic [3:0]          r_cmd, w_cmd_nxt;
   logic [BANK_W-1:0]   r_ba, w_ba_nxt;
   logic [ROW_W-1:0]    r_a, w_a_nxt;
   logic                r_done, w_done_nxt;
   logic                r_wr_act, w_wr_act_nxt;
   logic                r_rd_act, w_rd_act_nxt;
   logic                r_init_done, w_init_done_nxt;
   logic                r_ref_pend;
   logic [REF_W-1:0]    r_ref_cnt;
   logic                w_ref_expire, w_ref_issue, w_accept;
   logic [BANK_W-1:0]   r_bank;
   logic [COL_W-1:0]    r_col;
   logic                r_write;
   logic [BANK_W-1:0]   w_bank;
   logic [ROW_W-1:0]    w_row;
   logic [COL_W-1:0]    w_col;
   logic [ROW_W-1:0]    w_col_a;

   assign w_bank     = req_addr_i[COL_W+ROW_W +: BANK_W];
   assign w_row      = req_addr_i[COL_W +: ROW_W];
   assign w_col      = req_addr_i[COL_W-1:0];
   assign w_col_a    = ROW_W'(r_col) | A10;   // A10 selects auto-precharge
   assign w_cnt_dec  = r_cnt - CNT_W'(1);
   assign w_cnt_zero = (r_cnt == '0);

   // A pending refresh closes the door so the FSM takes REF on its next IDLE cycle.
   assign req_ready_o = (r_state == S_IDLE) & r_init_done & ~r_ref_pend;
   assign w_accept    = req_valid_i & req_ready_o;

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_cmd_nxt       = CMD_NOP;
      w_ba_nxt        = '0;
      w_a_nxt         = '0;
      w_done_nxt      = 1'b0;
      w_wr_act_nxt    = 1'b0;
      w_rd_act_nxt    = 1'b0;
      w_init_done_nxt = r_init_done;
      w_ref_issue     = 1'b0;
      case (r_state)
         S_INIT_WAIT: if (w_cnt_zero) begin
               w_cmd_nxt = CMD_PRE; w_a_nxt = A10;
               w_state_nxt = S_INIT_PRE; w_cnt_nxt = CNT_W'(RP_NOP);
            end else w_cnt_nxt = w_cnt_dec;
         S_INIT_PRE: if (w_cnt_zero) begin
               w_cmd_nxt = CMD_REF;
               w_state_nxt = S_INIT_REF1; w_cnt_nxt = CNT_W'(RFC_NOP);
            end else w_cnt_nxt = w_cnt_dec;
         S_INIT_REF1: if (w_cnt_zero) begin
               w_cmd_nxt = CMD_REF;
               w_state_nxt = S_INIT_REF2; w_cnt_nxt = CNT_W'(RFC_NOP);
            end else w_cnt_nxt = w_cnt_dec;
         S_INIT_REF2: if (w_cnt_zero) begin
               w_cmd_nxt = CMD_MRS; w_a_nxt = MODE_REG;
               w_state_nxt = S_INIT_MRS; w_cnt_nxt = CNT_W'(MRS_IDLE);
            end else w_cnt_nxt = w_cnt_dec;
         S_INIT_MRS: if (w_cnt_zero) begin
               w_state_nxt = S_IDLE; w_init_done_nxt = 1'b1;
            end else w_cnt_nxt = w_cnt_dec;
         S_IDLE: if (r_ref_pend) begin
               w_cmd_nxt = CMD_REF; w_ref_issue = 1'b1;
               w_state_nxt = S_REF; w_cnt_nxt = CNT_W'(RFC_IDLE);
            end else if (w_accept) begin
               // ACT uses the live address; bank/col are latched for the column command.
               w_cmd_nxt = CMD_ACT; w_ba_nxt = w_bank; w_a_nxt = w_row;
               w_state_nxt = S_ACT; w_cnt_nxt = CNT_W'(RCD_NOP);
            end
         S_REF: if (w_cnt_zero) w_state_nxt = S_IDLE;
            else w_cnt_nxt = w_cnt_dec;
         S_ACT: if (w_cnt_zero) begin
               w_ba_nxt = r_bank; w_a_nxt = w_col_a;
               if (r_write) begin
                  // Data and WR leave on the same edge.
                  w_cmd_nxt = CMD_WR; w_wr_act_nxt = 1'b1; w_done_nxt = 1'b1;
                  w_state_nxt = S_RECOVER; w_cnt_nxt = CNT_W'(WR_IDLE);
               end else begin
                  w_cmd_nxt = CMD_RD;
                  w_state_nxt = S_CAS; w_cnt_nxt = CNT_W'(CAS_WAIT);
               end
            end else w_cnt_nxt = w_cnt_dec;
         S_CAS: if (w_cnt_zero) begin
               w_rd_act_nxt = 1'b1; w_done_nxt = 1'b1;
               w_state_nxt = S_RECOVER; w_cnt_nxt = CNT_W'(RP_IDLE);
            end else w_cnt_nxt = w_cnt_dec;
         S_RECOVER: if (w_cnt_zero) w_state_nxt = S_IDLE;
            else w_cnt_nxt = w_cnt_dec;
         default: w_state_nxt = S_INIT_WAIT;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= S_INIT_WAIT;
         r_cnt       <= CNT_W'(INIT_CNT);
         r_cke       <= 1'b0;
         r_cmd       <= CMD_DES;
         r_ba        <= '0;
         r_a         <= '0;
         r_done      <= 1'b0;
         r_wr_act    <= 1'b0;
         r_rd_act    <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cke       <= 1'b1;
         r_cmd       <= w_cmd_nxt;
         r_ba        <= w_ba_nxt;
         r_a         <= w_a_nxt;
         r_done      <= w_done_nxt;
         r_wr_act    <= w_wr_act_nxt;
         r_rd_act    <= w_rd_act_nxt;
         r_init_done <= w_init_done_nxt;
      end
   end

   // Refresh timer only runs after init; a new expiry wins over the clear so
   // back-to-back events never lose a refresh, but at most one is ever pending.
   assign w_ref_expire = r_init_done & (r_ref_cnt == '0);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_ref_cnt  <= REF_W'(REF_INTERVAL - 1);
         r_ref_pend <= 1'b0;
      end else if (r_init_done) begin
         r_ref_cnt <= w_ref_expire ? REF_W'(REF_INTERVAL - 1) : r_ref_cnt - REF_W'(1);
         if (w_ref_expire)     r_ref_pend <= 1'b1;
         else if (w_ref_issue) r_ref_pend <= 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (w_accept) begin
         r_bank  <= w_bank;
         r_col   <= w_col;
         r_write <= req_write_i;
      end
   end

   assign {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N} = r_cmd;
   assign SDRAM_CKE           = r_cke;
   assign SDRAM_BA            = r_ba;
   assign SDRAM_A             = r_a;
   assign done_o              = r_done;
   assign init_done_o         = r_init_done;
   assign cmd_write_active_o  = r_wr_act;
   assign cmd_read_active_o   = r_rd_act;
   assign sdram_rdata_valid_o = r_rd_act;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sdram_cmd_sequencer
//   Scoreboard bench: every driven request (and the init sequence) pushes the
//   commands and data strobes it must produce; a negedge monitor pops and
//   compares them as they appear on the pins. Post-init REFs are logged with
//   their cycle and checked against hand-derived times.
// ---------------------------------------------------------------------------
module tb_sdram_cmd_sequencer;

   localparam int T_RFC = 7;
   localparam logic [3:0] C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100,
                          C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

   logic        HCLK, HRESETn, req_valid_i, req_write_i;
   logic [23:0] req_addr_i;
   logic        req_ready_o, done_o, init_done_o;
   logic        cmd_write_active_o, cmd_read_active_o, sdram_rdata_valid_o;
   logic        SDRAM_CKE, SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N;
   logic [1:0]  SDRAM_BA;
   logic [12:0] SDRAM_A;

   sdram_cmd_sequencer #(.INIT_WAIT(20), .REF_INTERVAL(100)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
      .req_ready_o(req_ready_o), .done_o(done_o), .init_done_o(init_done_o),
      .cmd_write_active_o(cmd_write_active_o), .cmd_read_active_o(cmd_read_active_o),
      .sdram_rdata_valid_o(sdram_rdata_valid_o),
      .SDRAM_CKE(SDRAM_CKE), .SDRAM_CS_N(SDRAM_CS_N), .SDRAM_RAS_N(SDRAM_RAS_N),
      .SDRAM_CAS_N(SDRAM_CAS_N), .SDRAM_WE_N(SDRAM_WE_N),
      .SDRAM_BA(SDRAM_BA), .SDRAM_A(SDRAM_A)
   );

   typedef struct { logic [3:0] cmd; logic [1:0] ba; logic [12:0] a; int cyc; } cmd_t;
   typedef struct { int cyc; logic rd; } strb_t;

   cmd_t  exp_q[$];
   strb_t done_q[$];
   int    ref_q[$];
   int    n_checks = 0, n_errors = 0;
   int    cyc;
   logic  in_init = 1'b1;
   cmd_t  m_e;
   strb_t m_d;
   logic [3:0] m_c;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   always @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) cyc <= 0;
      else          cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [25:0] pins();
      return {SDRAM_CKE, SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N, SDRAM_BA, SDRAM_A,
              req_ready_o, done_o, init_done_o, cmd_write_active_o, cmd_read_active_o,
              sdram_rdata_valid_o};
   endfunction

   localparam logic [25:0] RESET_PINS = {1'b0, 4'b1111, 2'b00, 13'h0, 6'b0};

   // Command / strobe monitor
   always @(negedge HCLK) begin
      if (HRESETn) begin
         m_c = {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N};
         if (m_c[3] == 1'b0 && m_c[2:0] != 3'b111) begin
            if (m_c == C_REF && !in_init) begin
               ref_q.push_back(cyc);
            end else if (exp_q.size() == 0) begin
               chk("unexpected_cmd", {28'h0, m_c}, 32'h7);
            end else begin
               m_e = exp_q.pop_front();
               chk("cmd", {28'h0, m_c}, {28'h0, m_e.cmd});
               chk("cmd_ba", {30'h0, SDRAM_BA}, {30'h0, m_e.ba});
               chk("cmd_a", {19'h0, SDRAM_A}, {19'h0, m_e.a});
               chk("cmd_cycle", cyc, m_e.cyc);
               if (m_c == C_ACT && ref_q.size() > 0)
                  chk("act_after_ref_gap", {31'h0, (cyc - ref_q[$]) > T_RFC}, 1);
            end
         end
         if (done_o || cmd_write_active_o || cmd_read_active_o || sdram_rdata_valid_o) begin
            if (done_q.size() == 0) begin
               chk("unexpected_strobe",
                   {28'h0, done_o, cmd_write_active_o, cmd_read_active_o, sdram_rdata_valid_o}, 0);
            end else begin
               m_d = done_q.pop_front();
               chk("strobe_cycle", cyc, m_d.cyc);
               chk("strobe_set",
                   {28'h0, done_o, cmd_write_active_o, cmd_read_active_o, sdram_rdata_valid_o},
                   m_d.rd ? 32'hB : 32'hC);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc != n && guard < 1000) begin
         @(negedge HCLK);
         guard++;
      end
      if (cyc != n) chk("wait_timeout", cyc, n);
   endtask

   // Present a request and hold it until accepted; returns the accept edge.
   task automatic send(input logic wr, input logic [23:0] ad, output int acc);
      int guard = 0;
      acc = -1;
      req_valid_i = 1'b1; req_write_i = wr; req_addr_i = ad;
      while (!req_ready_o && guard < 400) begin
         @(negedge HCLK);
         guard++;
      end
      if (!req_ready_o) begin
         chk("accept_timeout", 0, 1);
         return;
      end
      acc = cyc + 1;
      exp_q.push_back('{cmd: C_ACT, ba: ad[23:22], a: ad[21:9], cyc: acc});
      exp_q.push_back('{cmd: wr ? C_WR : C_RD, ba: ad[23:22],
                        a: {2'b00, 1'b1, 1'b0, ad[8:0]}, cyc: acc + 2});
      done_q.push_back('{cyc: acc + (wr ? 2 : 4), rd: !wr});
      @(negedge HCLK);
   endtask

   // Called at a negedge with reset low; releases reset and walks the init.
   task automatic run_init();
      in_init = 1'b1;
      exp_q.push_back('{cmd: C_PRE, ba: 2'd0, a: 13'h400, cyc: 21});
      exp_q.push_back('{cmd: C_REF, ba: 2'd0, a: 13'h000, cyc: 24});
      exp_q.push_back('{cmd: C_REF, ba: 2'd0, a: 13'h000, cyc: 32});
      exp_q.push_back('{cmd: C_MRS, ba: 2'd0, a: 13'h020, cyc: 40});
      HRESETn = 1'b1;
      #1 chk("cke_before_first_edge", {31'h0, SDRAM_CKE}, 0);
      wait_cyc(1);
      chk("cke_after_release", {31'h0, SDRAM_CKE}, 1);
      wait_cyc(41);
      chk("init_not_done_41", {30'h0, init_done_o, req_ready_o}, 0);
      wait_cyc(42);
      chk("init_done_42", {31'h0, init_done_o}, 1);
      chk("init_queue_drained", exp_q.size(), 0);
      in_init = 1'b0;
   endtask

   initial begin
      int acc;
      HRESETn = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
      repeat (3) @(negedge HCLK);
      chk("reset_pins", {6'h0, pins()}, {6'h0, RESET_PINS});

      // 1/2: write held valid through init must wait, then go at the first IDLE cycle
      req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = {2'd1, 13'h123, 9'h045};
      run_init();
      send(1'b1, {2'd1, 13'h123, 9'h045}, acc);
      chk("wr_accept_cycle", acc, 43);
      req_valid_i = 1'b0;
      wait_cyc(48);
      chk("ready_low_48", {31'h0, req_ready_o}, 0);
      wait_cyc(49);
      chk("ready_high_49", {31'h0, req_ready_o}, 1);

      // 3: read at the far corner of the address space
      send(1'b0, {2'd3, 13'h1FFF, 9'h1FF}, acc);
      chk("rd_accept_cycle", acc, 50);

      // 4: continuous writes across the first refresh expiry (edge 142)
      for (int k = 0; k < 25; k++) begin
         logic [23:0] ad;
         ad = {k[1:0], 13'(16'h0100 + k), 9'(k * 3)};
         send(1'b1, ad, acc);
         if (k == 0)  chk("wr_stream_first", acc, 57);
         if (k == 13) chk("wr_after_ref", acc, 156);
      end

      // 5: read in flight when the second expiry (edge 242) lands
      send(1'b0, {2'd2, 13'h0AAA, 9'h155}, acc);
      chk("rd_inflight_accept", acc, 240);
      req_valid_i = 1'b0;
      wait_cyc(260);
      chk("ref_count", ref_q.size(), 2);
      if (ref_q.size() == 2) begin
         chk("ref1_cycle", ref_q[0], 148);
         chk("ref2_cycle", ref_q[1], 247);
      end

      // 6: reset between ACT and RD
      send(1'b0, {2'd0, 13'h0777, 9'h033}, acc);
      chk("pre_reset_accept", acc, 261);
      req_valid_i = 1'b0;
      #2 HRESETn = 1'b0;
      in_init = 1'b1;
      #1 chk("midop_reset_pins", {6'h0, pins()}, {6'h0, RESET_PINS});
      chk("pending_rd_left", exp_q.size(), 1);
      if (exp_q.size() == 1) chk("pending_is_rd", {28'h0, exp_q[0].cmd}, {28'h0, C_RD});
      chk("pending_strobe_left", done_q.size(), 1);
      exp_q.delete();
      done_q.delete();
      repeat (3) @(negedge HCLK);
      chk("held_reset_pins", {6'h0, pins()}, {6'h0, RESET_PINS});
      run_init();
      wait_cyc(50);
      chk("final_cmd_queue", exp_q.size(), 0);
      chk("final_strobe_queue", done_q.size(), 0);
      chk("final_ready", {31'h0, req_ready_o}, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
